// File: rtl/dcache_writeback.sv
// rtl/dcache_writeback.sv - D-cache victim writeback engine driven by the dirty table
module dcache_writeback #(
  parameter int addr_width     = 4,
  parameter int tag_width      = 24,
  parameter int words_per_line = 4,
  parameter int data_width     = 32
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 wb_req,
  input  logic                                 wb_way,
  input  logic [addr_width-1:0]                wb_index,
  input  logic [tag_width-1:0]                 wb_tag,
  input  logic [data_width*words_per_line-1:0] wb_line,
  output logic                                 wb_ready,
  output logic                                 wb_done,
  output logic                                 wb_wrote,
  output logic [addr_width-1:0]                dt_addr,
  output logic                                 dt_way_select,
  input  logic                                 dt_dirty,
  output logic                                 dt_set0,
  output logic                                 mem_wr_req,
  output logic [31:0]                          mem_wr_addr,
  output logic [data_width-1:0]                mem_wr_data,
  output logic                                 mem_wr_last,
  input  logic                                 mem_wr_ready
);

  localparam int cnt_width = $clog2(words_per_line);

  typedef enum logic [2:0] {IDLE, CHECK, SEND, CLEAR, DONE} state_t;

  state_t                  state;
  logic                    way_q;
  logic [addr_width-1:0]   index_q;
  logic [tag_width-1:0]    tag_q;
  logic [data_width-1:0]   words_q [words_per_line];
  logic [cnt_width-1:0]    cnt;
  logic [cnt_width-1:0]    cnt_inc;

  // Word counter advanced on each accepted write; wraps naturally at line end
  assign cnt_inc = cnt + cnt_width'(1);

  // Dirty-table lookup always points at the latched victim
  assign dt_addr       = index_q;
  assign dt_way_select = way_q;

  // Writeback FSM; every output is registered and updated with the state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      way_q       <= 1'b0;
      index_q     <= '0;
      tag_q       <= '0;
      for (int k = 0; k < words_per_line; k++) words_q[k] <= '0;
      cnt         <= '0;
      wb_ready    <= 1'b1;
      wb_done     <= 1'b0;
      wb_wrote    <= 1'b0;
      dt_set0     <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_last <= 1'b0;
    end else begin
      wb_done <= 1'b0;
      dt_set0 <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_req) begin
            way_q   <= wb_way;
            index_q <= wb_index;
            tag_q   <= wb_tag;
            for (int k = 0; k < words_per_line; k++)
              words_q[k] <= wb_line[k*data_width +: data_width];
            cnt      <= '0;
            wb_ready <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (dt_dirty) begin
            mem_wr_req  <= 1'b1;
            mem_wr_addr <= {tag_q, index_q, {cnt_width{1'b0}}, 2'b00};
            mem_wr_data <= words_q[0];
            mem_wr_last <= 1'b0;
            state       <= SEND;
          end else begin
            wb_done  <= 1'b1;
            wb_wrote <= 1'b0;
            state    <= DONE;
          end
        end
        SEND: begin
          // Address/data/last only move on a handshake, so they hold through stalls
          if (mem_wr_ready) begin
            cnt <= cnt_inc;
            if (mem_wr_last) begin
              mem_wr_req  <= 1'b0;
              mem_wr_last <= 1'b0;
              dt_set0     <= 1'b1;
              state       <= CLEAR;
            end else begin
              mem_wr_addr <= {tag_q, index_q, cnt_inc, 2'b00};
              mem_wr_data <= words_q[cnt_inc];
              mem_wr_last <= (cnt_inc == cnt_width'(words_per_line - 1));
            end
          end
        end
        CLEAR: begin
          wb_done  <= 1'b1;
          wb_wrote <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          wb_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          wb_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
